video_timing_gen: RTL and testbench

Parametrised raster timing generator and framebuffer fetch unit. It drives the scan-out path: it produces sync, blank and pixel-enable for any progressive mode, fetches pixels from the framebuffer through a fixed-latency read port, and expands RGB332 or RGB565 words to 24-bit RGB. Pixel addressing is incremental, with no multiplier. Blanked pixels are forced to black.

---
 rtl/video_timing_gen.sv | 214 +++++++++++++++++++++
 tb/tb_video_timing_gen.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// Raster timing generator and framebuffer fetch with RGB332/RGB565 expansion; VIDEO_GEN_DOUBLE_EN selects double-scan.
// All outputs for a pixel appear RD_LAT+1 clocks after its tick; free-running, no backpressure (fixed-latency read port).
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CLK_DIV  = 2,
  parameter int RD_LAT   = 1,
  parameter int ADDR_W   = 19
) (
  input  logic              clk_vid,
  input  logic              reset,
  input  logic              fmt,
  output logic [ADDR_W-1:0] addr,
  output logic              rd,
  input  logic [15:0]       din,
  output logic              ce_pxl,
  output logic              hsync,
  output logic              vsync,
  output logic              hblank,
  output logic              vblank,
  output logic [7:0]        red,
  output logic [7:0]        green,
  output logic [7:0]        blue,
  output logic              line_start,
  output logic              frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  typedef struct packed {
    logic ce;
    logic rd;
    logic hs;
    logic vs;
    logic hb;
    logic vb;
    logic ls;
    logic fs;
    logic fmt;
  } stg_t;

  localparam stg_t STG_RST = '{ce: 1'b0, rd: 1'b0, hs: 1'b0, vs: 1'b0, hb: 1'b1,
                               vb: 1'b1, ls: 1'b0, fs: 1'b0, fmt: 1'b0};

  logic [DW-1:0] div;
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic          tick, h_end, v_end, h_act, v_act, active, frame_tick;
  logic          fmt_q;

  assign tick       = (div == DIV_LAST) && !reset;
  assign h_end      = (h == H_LAST);
  assign v_end      = (v == V_LAST);
  assign h_act      = (h < H_ACT);
  assign v_act      = (v < V_ACT);
  assign active     = h_act && v_act;
  assign frame_tick = tick && (h == '0) && (v == '0);

  always_ff @(posedge clk_vid) begin
    if (reset) begin
      div <= '0;
      h   <= '0;
      v   <= '0;
    end else begin
      div <= (div == DIV_LAST) ? '0 : div + DW'(1);
      if (tick) begin
        if (h_end) begin
          h <= '0;
          v <= v_end ? '0 : v + VW'(1);
        end else begin
          h <= h + HW'(1);
        end
      end
    end
  end

  logic [ADDR_W-1:0] ptr;
  assign addr = ptr;

`ifdef VIDEO_GEN_DOUBLE_EN
  localparam logic [ADDR_W-1:0] HALF = ADDR_W'(H_ACTIVE / 2);
  logic [ADDR_W-1:0] base;

  assign rd = tick && active && !h[0];

  // Even lines rewind to the line base; odd lines move the base on to the next source row.
  always_ff @(posedge clk_vid) begin
    if (reset) begin
      ptr  <= '0;
      base <= '0;
    end else if (tick) begin
      if (h_end && v_end) begin
        ptr  <= '0;
        base <= '0;
      end else if (h_end && v_act) begin
        if (v[0]) begin
          base <= base + HALF;
          ptr  <= base + HALF;
        end else begin
          ptr  <= base;
        end
      end else if (rd) begin
        ptr <= ptr + ADDR_W'(1);
      end
    end
  end
`else
  assign rd = tick && active;

  always_ff @(posedge clk_vid) begin
    if (reset) begin
      ptr <= '0;
    end else if (tick && h_end && v_end) begin
      ptr <= '0;
    end else if (rd) begin
      ptr <= ptr + ADDR_W'(1);
    end
  end
`endif

  always_ff @(posedge clk_vid) begin
    if (reset) begin
      fmt_q <= 1'b0;
    end else if (frame_tick) begin
      fmt_q <= fmt;
    end
  end

  // The frame's format rides with each pixel so the first pixel already sees the newly latched value.
  stg_t cur;
  always_comb begin
    cur     = STG_RST;
    cur.ce  = tick;
    cur.rd  = rd;
    cur.hs  = (h >= HS_BEG) && (h < HS_END);
    cur.vs  = (v >= VS_BEG) && (v < VS_END);
    cur.hb  = !h_act;
    cur.vb  = !v_act;
    cur.ls  = tick && (h == '0);
    cur.fs  = frame_tick;
    cur.fmt = frame_tick ? fmt : fmt_q;
  end

  stg_t pipe [RD_LAT+1];

  always_ff @(posedge clk_vid) begin
    if (reset) begin
      for (int i = 0; i <= RD_LAT; i++) pipe[i] <= STG_RST;
    end else begin
      pipe[0] <= cur;
      for (int i = 1; i <= RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  // Stage aligned with din: RD_LAT clocks after the tick.
  logic din_ce, din_rd, din_blank, din_fmt;
  if (RD_LAT == 0) begin : g_lat0
    assign din_ce    = cur.ce;
    assign din_rd    = cur.rd;
    assign din_blank = cur.hb || cur.vb;
    assign din_fmt   = cur.fmt;
  end else begin : g_latn
    assign din_ce    = pipe[RD_LAT-1].ce;
    assign din_rd    = pipe[RD_LAT-1].rd;
    assign din_blank = pipe[RD_LAT-1].hb || pipe[RD_LAT-1].vb;
    assign din_fmt   = pipe[RD_LAT-1].fmt;
  end

  function automatic logic [23:0] expand(input logic [15:0] d, input logic f);
    if (f) return {d[15:11], d[15:13], d[10:5], d[10:9], d[4:0], d[4:2]};
    return {d[7:5], d[7:5], d[7:6], d[4:2], d[4:2], d[4:3], {4{d[1:0]}}};
  endfunction

  // Double-scan repeat ticks carry no read, so the colour simply holds.
  always_ff @(posedge clk_vid) begin
    if (reset) begin
      {red, green, blue} <= '0;
    end else if (din_ce) begin
      if (din_blank)   {red, green, blue} <= '0;
      else if (din_rd) {red, green, blue} <= expand(din, din_fmt);
    end
  end

  assign ce_pxl      = pipe[RD_LAT].ce;
  assign hsync       = pipe[RD_LAT].hs ? HS_POL : ~HS_POL;
  assign vsync       = pipe[RD_LAT].vs ? VS_POL : ~VS_POL;
  assign hblank      = pipe[RD_LAT].hb;
  assign vblank      = pipe[RD_LAT].vb;
  assign line_start  = pipe[RD_LAT].ls;
  assign frame_start = pipe[RD_LAT].fs;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on a small 15x8 raster with RD_LAT=3: raster model plus
// scoreboard of per-tick expectations, colour-expansion vector table, reset and fmt corner cases.
module tb_video_timing_gen;

  localparam int H_A = 8, H_F = 2, H_S = 3, H_B = 2;
  localparam int V_A = 4, V_F = 1, V_S = 2, V_B = 1;
  localparam int CD = 2, RL = 3, AW = 10;
  localparam bit HP = 1'b0, VP = 1'b1;
  localparam int H_T = H_A + H_F + H_S + H_B;
  localparam int V_T = V_A + V_F + V_S + V_B;
  localparam int FRAME = H_T * V_T * CD;
`ifdef VIDEO_GEN_DOUBLE_EN
  localparam bit DBL = 1'b1;
`else
  localparam bit DBL = 1'b0;
`endif

  logic          clk_vid = 1'b0;
  logic          reset = 1'b1;
  logic          fmt = 1'b0;
  logic [AW-1:0] addr;
  logic          rd;
  logic [15:0]   din = 16'h0;
  logic          ce_pxl, hsync, vsync, hblank, vblank, line_start, frame_start;
  logic [7:0]    red, green, blue;

  video_timing_gen #(
    .H_ACTIVE(H_A), .H_FP(H_F), .H_SYNC(H_S), .H_BP(H_B),
    .V_ACTIVE(V_A), .V_FP(V_F), .V_SYNC(V_S), .V_BP(V_B),
    .HS_POL(HP), .VS_POL(VP), .CLK_DIV(CD), .RD_LAT(RL), .ADDR_W(AW)
  ) dut (
    .clk_vid(clk_vid), .reset(reset), .fmt(fmt), .addr(addr), .rd(rd), .din(din),
    .ce_pxl(ce_pxl), .hsync(hsync), .vsync(vsync), .hblank(hblank), .vblank(vblank),
    .red(red), .green(green), .blue(blue), .line_start(line_start), .frame_start(frame_start)
  );

  always #5 clk_vid = ~clk_vid;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] exp_rgb(input logic [15:0] d, input bit f);
    logic [7:0] r, g, b;
    if (f) begin
      r = {d[15:11], d[15:13]};
      g = {d[10:5], d[10:9]};
      b = {d[4:0], d[4:2]};
    end else begin
      r = {d[7:5], d[7:5], d[7:6]};
      g = {d[4:2], d[4:2], d[4:3]};
      b = {d[1:0], d[1:0], d[1:0], d[1:0]};
    end
    return {r, g, b};
  endfunction

  typedef struct {
    int          due;
    logic [6:0]  fl;
    logic [23:0] rgb;
  } exp_t;
  exp_t sbq[$];

  // Model and memory state
  int          cyc = 0, mdiv = 0, mh = 0, mv = 0;
  bit          mfmt = 1'b0, chk_en = 1'b0, cur_fmt = 1'b0, dmode = 1'b0;
  logic [15:0] dconst = 16'h0;
  logic [15:0] hist [8];
  bit          t_flag = 1'b0;
  int          t_h = 0, t_v = 0;

  // Measurements
  int          hs_ticks = 0, vs_ticks = 0, rd_cnt = 0, max_addr = -1;
  int          last_fs = -1, fs_period = 0;
  logic [23:0] last_rgb = 24'hDEAD00;
  bit          want_first_fs = 1'b0;

  function automatic logic [15:0] mem(input int a);
    return dmode ? dconst : 16'(a);
  endfunction

  task automatic cycle(input bit rst_i);
    exp_t        e;
    bit          tick, hact, vact, hs, vs, exp_rd;
    int          ea;
    logic [15:0] dat;
    @(negedge clk_vid);
    reset = rst_i;
    fmt   = cur_fmt;
    #1;
    cyc++;
    if (chk_en) begin
      if (sbq.size() > 0 && sbq[0].due <= cyc) begin
        e = sbq.pop_front();
        check("pixel timing flags", {ce_pxl, hsync, vsync, hblank, vblank, line_start, frame_start}, e.fl);
        check("pixel rgb", {red, green, blue}, e.rgb);
        check("pixel due cycle", cyc, e.due);
      end else begin
        check("idle ce/line/frame", {ce_pxl, line_start, frame_start}, 3'b000);
      end
    end
    if (ce_pxl === 1'b1) begin
      if (hsync === HP) hs_ticks++;
      if (vsync === VP) vs_ticks++;
      if (hblank === 1'b0 && vblank === 1'b0) last_rgb = {red, green, blue};
      if (want_first_fs) begin
        check("first pixel after reset is frame start", frame_start, 1'b1);
        want_first_fs = 1'b0;
      end
    end
    if (frame_start === 1'b1) begin
      if (last_fs >= 0) fs_period = cyc - last_fs;
      last_fs = cyc;
    end
    if (rd === 1'b1) begin
      rd_cnt++;
      if (int'(addr) > max_addr) max_addr = int'(addr);
    end
    hist[cyc % 8] = (rd === 1'b1) ? mem(int'(addr)) : 16'hBAD5;
    din = hist[(cyc - RL + 8) % 8];

    tick   = !rst_i && (mdiv == CD - 1);
    exp_rd = 1'b0;
    t_flag = tick;
    if (tick) begin
      t_h  = mh;
      t_v  = mv;
      hact = mh < H_A;
      vact = mv < V_A;
      hs   = (mh >= H_A + H_F) && (mh < H_A + H_F + H_S);
      vs   = (mv >= V_A + V_F) && (mv < V_A + V_F + V_S);
      if (mh == 0 && mv == 0) mfmt = cur_fmt;
      ea     = DBL ? (mv / 2) * (H_A / 2) + mh / 2 : mv * H_A + mh;
      exp_rd = hact && vact && (!DBL || (mh % 2 == 0));
      dat    = dmode ? dconst : 16'(ea);
      if (chk_en && exp_rd) check("read address", addr, ea);
      e.due = cyc + RL + 1;
      e.fl  = {1'b1, hs ? HP : !HP, vs ? VP : !VP, !hact, !vact, mh == 0, mh == 0 && mv == 0};
      e.rgb = (hact && vact) ? exp_rgb(dat, mfmt) : 24'h0;
      sbq.push_back(e);
      if (mh == H_T - 1) begin
        mh = 0;
        mv = (mv == V_T - 1) ? 0 : mv + 1;
      end else begin
        mh++;
      end
    end
    if (chk_en) check("read strobe", rd, exp_rd);
    if (rst_i) begin
      mdiv = 0; mh = 0; mv = 0;
      sbq.delete();
    end else begin
      mdiv = (mdiv == CD - 1) ? 0 : mdiv + 1;
    end
  endtask

  task automatic run_cycles(input int n);
    repeat (n) cycle(1'b0);
  endtask

  task automatic run_to(input int h, input int v);
    for (int k = 0; k < 2 * FRAME; k++) begin
      cycle(1'b0);
      if (t_flag && t_h == h && t_v == v) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL run_to: tick at (%0d,%0d) not seen within %0d cycles", h, v, 2 * FRAME);
  endtask

  typedef struct {
    bit          f;
    logic [15:0] d;
    logic [23:0] rgb;
  } tv_t;
  tv_t tv [9];

  logic [41:0] rst_vec;
  logic [41:0] rst_exp;

  initial begin
    tv[0] = '{1'b0, 16'h00E0, 24'hFF0000};
    tv[1] = '{1'b0, 16'h001C, 24'h00FF00};
    tv[2] = '{1'b0, 16'h0003, 24'h0000FF};
    tv[3] = '{1'b0, 16'h006D, 24'h6D6D55};
    tv[4] = '{1'b0, 16'hFF00, 24'h000000};
    tv[5] = '{1'b1, 16'h8410, 24'h848284};
    tv[6] = '{1'b1, 16'hF800, 24'hFF0000};
    tv[7] = '{1'b1, 16'h07E0, 24'h00FF00};
    tv[8] = '{1'b1, 16'h0821, 24'h080408};
    for (int i = 0; i < 8; i++) hist[i] = 16'hBAD5;
    rst_exp = {10'd0, 1'b0, 1'b0, !HP, !VP, 1'b1, 1'b1, 24'h0, 2'b00};

    // Reset state
    repeat (4) cycle(1'b1);
    rst_vec = {addr, rd, ce_pxl, hsync, vsync, hblank, vblank, red, green, blue, line_start, frame_start};
    check("reset state outputs", rst_vec, rst_exp);
    chk_en = 1'b1;
    want_first_fs = 1'b1;

    // Free run, din = addr, RGB565: sync widths, read count, frame period
    dmode = 1'b0;
    cur_fmt = 1'b1;
    run_to(0, 0);
    run_to(0, 0);
    hs_ticks = 0; vs_ticks = 0; rd_cnt = 0; max_addr = -1;
    run_cycles(FRAME);
    check("hsync active ticks per frame", hs_ticks, H_S * V_T);
    check("vsync active ticks per frame", vs_ticks, V_S * H_T);
    check("reads per frame", rd_cnt, DBL ? (H_A / 2) * (V_A / 2) * 2 : H_A * V_A);
    check("max read address", max_addr, DBL ? (H_A / 2) * (V_A / 2) - 1 : H_A * V_A - 1);
    check("frame period clocks", fs_period, FRAME);

    // Colour expansion table, one latched frame each
    dmode = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cur_fmt = tv[i].f;
      dconst  = tv[i].d;
      run_cycles(FRAME);
      last_rgb = 24'hDEAD00;
      run_cycles(FRAME);
      check($sformatf("expand fmt=%0d din=%h", tv[i].f, tv[i].d), last_rgb, tv[i].rgb);
    end

    // fmt toggled mid-frame takes effect only at the next frame start
    dconst  = 16'h8410;
    cur_fmt = 1'b1;
    run_to(0, 0);
    run_to(2, 1);
    cur_fmt  = 1'b0;
    last_rgb = 24'hDEAD00;
    run_to(0, 0);
    check("fmt change ignored mid-frame", last_rgb, 24'h848284);
    last_rgb = 24'hDEAD00;
    run_cycles(FRAME);
    check("fmt change applied next frame", last_rgb, 24'h009200);

    // One-clock reset mid-frame
    dmode   = 1'b0;
    cur_fmt = 1'b1;
    run_to(5, 2);
    cycle(1'b1);
    cycle(1'b0);
    rst_vec = {addr, rd, ce_pxl, hsync, vsync, hblank, vblank, red, green, blue, line_start, frame_start};
    check("outputs after mid-frame reset", rst_vec, rst_exp);
    want_first_fs = 1'b1;
    run_cycles(RL + 2 * CD + 2);
    check("first pixel after reset seen", want_first_fs, 1'b0);
    run_cycles(FRAME);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
